// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM state encodings and alignment helpers for the load/store unit.
package lsu_pkg;
   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;
   localparam logic [1:0] MEM_SIZE_D = 2'd3;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   function automatic logic misaligned(input logic [2:0] a, input logic [1:0] s);
      return (s == MEM_SIZE_H && a[0]) || (s == MEM_SIZE_W && a[1:0] != 2'd0) ||
             (s == MEM_SIZE_D && a != 3'd0);
   endfunction
   function automatic logic [7:0] size_mask(input logic [1:0] s);
      return s == MEM_SIZE_B ? 8'h01 : s == MEM_SIZE_H ? 8'h03 : s == MEM_SIZE_W ? 8'h0f : 8'hff;
   endfunction
endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: selects the addressed bytes of an aligned 64-bit word and sign/zero extends them.
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  lane,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [63:0] data
);
   logic [63:0] s;
   assign s = rdata >> {lane, 3'b000};
   assign data = size == MEM_SIZE_B ? {{56{~uns & s[7]}}, s[7:0]} :
                 size == MEM_SIZE_H ? {{48{~uns & s[15]}}, s[15:0]} :
                 size == MEM_SIZE_W ? {{32{~uns & s[31]}}, s[31:0]} : s;
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit; latches one op, issues one aligned 64-bit
// memory transaction and returns extended load data (or a misalignment flag) to writeback.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_we,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_resp_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rdata,
   output logic              out_misalign
);
   logic [1:0]        state, size_q;
   logic              we_q, uns_q, mis_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q, rdata_q, ext;
   lsu_extend u_extend (
      .rdata(mem_resp_rdata),
      .lane (addr_q[2:0]),
      .size (size_q),
      .uns  (uns_q),
      .data (ext)
   );
   // Request fields derive only from latched state, so they stay stable under back-pressure.
   assign in_ready      = state == S_IDLE;
   assign mem_req_valid = state == S_REQ;
   assign mem_req_we    = we_q;
   assign mem_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
   assign mem_req_wmask = size_mask(size_q) << addr_q[2:0];
   assign mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
   assign out_valid     = state == S_DONE;
   assign out_rdata     = rdata_q;
   assign out_misalign  = mis_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               we_q    <= in_we;
               size_q  <= in_size;
               uns_q   <= in_unsigned;
               addr_q  <= in_addr;
               wdata_q <= in_wdata;
               rdata_q <= '0;
               mis_q   <= misaligned(in_addr[2:0], in_size);
               state   <= misaligned(in_addr[2:0], in_size) ? S_DONE : S_REQ;
            end
            S_REQ:  if (mem_req_ready) state <= S_WAIT;
            S_WAIT: if (mem_resp_valid) begin
               rdata_q <= we_q ? '0 : ext;
               state   <= S_DONE;
            end
            default: if (out_ready) state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed tests for lsu with hand-computed expectations.
module tb_lsu;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_we = 1'b0, in_unsigned = 1'b0;
   logic [1:0]  in_size = 2'd0;
   logic [63:0] in_addr = '0, in_wdata = '0;
   logic        in_ready, mem_req_valid, mem_req_we, out_valid, out_misalign;
   logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0, out_ready = 1'b0;
   logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = '0, out_rdata;
   logic [7:0]  mem_req_wmask;
   int          n_cmp = 0, n_err = 0;
   int          lat, nreq;
   logic [63:0] ra, rw, rr;
   logic [7:0]  rm;
   logic        rwe, rmis;

   always #5 clk = ~clk;

   lsu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_rdata(out_rdata), .out_misalign(out_misalign)
   );

   task automatic present(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata);
      in_valid = 1'b1; in_we = we; in_size = size; in_unsigned = uns; in_addr = addr; in_wdata = wdata;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Zero-wait memory and writeback; records what the bus and output showed.
   task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata);
      logic got;
      got = 1'b0; nreq = 0; lat = 1;
      present(we, size, uns, addr, wdata);
      for (int i = 0; i < 20 && !out_valid; i++) begin
         if (mem_req_valid) begin
            ra = mem_req_addr; rw = mem_req_wdata; rm = mem_req_wmask; rwe = mem_req_we; nreq++;
         end
         mem_req_ready = mem_req_valid;
         mem_resp_valid = got; mem_resp_rdata = rdata;
         got = mem_req_valid;
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = 99;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      rr = out_rdata; rmis = out_misalign;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", mem_req_valid); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_rdata !== 64'h0) begin n_err++; $display("FAIL reset_out_rdata got %h want 0", out_rdata); end
      n_cmp++; if (out_misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", out_misalign); end
      n_cmp++; if (mem_req_addr !== 64'h0) begin n_err++; $display("FAIL reset_req_addr got %h want 0", mem_req_addr); end
   endtask

   task automatic test_load_word;
      do_op(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 64'h8000_0001_1234_5678);
      n_cmp++; if (ra !== 64'h8000_0000) begin n_err++; $display("FAIL lw_req_addr got %h want 80000000", ra); end
      n_cmp++; if (rwe !== 1'b0) begin n_err++; $display("FAIL lw_req_we got %b want 0", rwe); end
      n_cmp++; if (rr !== 64'hFFFF_FFFF_8000_0001) begin n_err++; $display("FAIL lw_rdata got %h want ffffffff80000001", rr); end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL lw_latency got %0d want 3", lat); end
      n_cmp++; if (nreq !== 1) begin n_err++; $display("FAIL lw_nreq got %0d want 1", nreq); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lw_in_ready_after got %b want 1", in_ready); end
   endtask

   task automatic test_loads;
      do_op(1'b0, 2'd0, 1'b1, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000);
      n_cmp++; if (rr !== 64'h0000_0000_0000_00AB) begin n_err++; $display("FAIL lbu_rdata got %h want ab", rr); end
      do_op(1'b0, 2'd1, 1'b0, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000);
      n_cmp++; if (rr !== 64'hFFFF_FFFF_FFFF_8001) begin n_err++; $display("FAIL lh_rdata got %h want ffffffffffff8001", rr); end
      do_op(1'b0, 2'd2, 1'b1, 64'h8000_0000, 64'h0, 64'h1234_5678_9ABC_DEF0);
      n_cmp++; if (rr !== 64'h0000_0000_9ABC_DEF0) begin n_err++; $display("FAIL lwu_rdata got %h want 9abcdef0", rr); end
      do_op(1'b0, 2'd0, 1'b0, 64'h8000_0001, 64'h0, 64'h0000_0000_0000_8000);
      n_cmp++; if (rr !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_rdata got %h want ffffffffffffff80", rr); end
      do_op(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 64'hF123_4567_89AB_CDEF);
      n_cmp++; if (rr !== 64'hF123_4567_89AB_CDEF) begin n_err++; $display("FAIL ld_rdata got %h want f123456789abcdef", rr); end
      n_cmp++; if (ra !== 64'h8000_0008) begin n_err++; $display("FAIL ld_req_addr got %h want 80000008", ra); end
   endtask

   task automatic test_stores;
      do_op(1'b1, 2'd1, 1'b0, 64'h8000_0002, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF);
      n_cmp++; if (rm !== 8'h0C) begin n_err++; $display("FAIL sh_wmask got %h want 0c", rm); end
      n_cmp++; if (rw !== 64'h0000_0000_BEEF_0000) begin n_err++; $display("FAIL sh_wdata got %h want beef0000", rw); end
      n_cmp++; if (rwe !== 1'b1) begin n_err++; $display("FAIL sh_we got %b want 1", rwe); end
      n_cmp++; if (rr !== 64'h0) begin n_err++; $display("FAIL sh_rdata got %h want 0", rr); end
      do_op(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'hAA, 64'h0);
      n_cmp++; if (rm !== 8'h20) begin n_err++; $display("FAIL sb_wmask got %h want 20", rm); end
      n_cmp++; if (rw !== 64'h0000_AA00_0000_0000) begin n_err++; $display("FAIL sb_wdata got %h want 0000aa0000000000", rw); end
   endtask

   task automatic test_misalign;
      do_op(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 64'h0);
      n_cmp++; if (nreq !== 0) begin n_err++; $display("FAIL mis_nreq got %0d want 0", nreq); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL mis_latency got %0d want 1", lat); end
      n_cmp++; if (rmis !== 1'b1) begin n_err++; $display("FAIL mis_flag got %b want 1", rmis); end
      do_op(1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h1, 64'h0);
      n_cmp++; if (rmis !== 1'b1 || nreq !== 0) begin n_err++; $display("FAIL mis_sd got flag %b nreq %0d want 1 0", rmis, nreq); end
      do_op(1'b0, 2'd1, 1'b0, 64'h8000_0004, 64'h0, 64'h0000_7FFF_0000_0000);
      n_cmp++; if (rmis !== 1'b0 || rr !== 64'h7FFF) begin n_err++; $display("FAIL mis_clear got flag %b data %h want 0 7fff", rmis, rr); end
   endtask

   task automatic test_backpressure;
      int hs;
      hs = 0;
      present(1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'h0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0018 || mem_req_we !== 1'b0)
            begin n_err++; $display("FAIL bp_req_hold[%0d] got v%b a%h we%b want v1 a80000018 we0", i, mem_req_valid, mem_req_addr, mem_req_we); end
         @(negedge clk);
      end
      mem_req_ready = 1'b1;
      n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0018)
         begin n_err++; $display("FAIL bp_req_last got v%b a%h want v1 a80000018", mem_req_valid, mem_req_addr); end
      hs++;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL bp_wait[%0d] got rv%b ov%b want 0 0", i, mem_req_valid, out_valid); end
         @(negedge clk);
      end
      mem_resp_valid = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (out_valid !== 1'b1 || out_rdata !== 64'hDEAD_BEEF_CAFE_F00D || out_misalign !== 1'b0 || in_ready !== 1'b0)
            begin n_err++; $display("FAIL bp_out_hold[%0d] got ov%b d%h m%b ir%b want 1 deadbeefcafef00d 0 0", i, out_valid, out_rdata, out_misalign, in_ready); end
         if (mem_req_valid) hs++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++; if (hs !== 1 || in_ready !== 1'b1 || out_valid !== 1'b0)
         begin n_err++; $display("FAIL bp_finish got hs%0d ir%b ov%b want 1 1 0", hs, in_ready, out_valid); end
   endtask

   task automatic test_reset_in_wait;
      present(1'b0, 2'd2, 1'b0, 64'h8000_0000, 64'h0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_rdata !== 64'h0)
         begin n_err++; $display("FAIL rst_wait got ir%b rv%b ov%b d%h want 1 0 0 0", in_ready, mem_req_valid, out_valid, out_rdata); end
      @(negedge clk);
      rst = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1111_1111_1111_1111;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin n_err++; $display("FAIL rst_stray got ir%b ov%b want 1 0", in_ready, out_valid); end
      do_op(1'b0, 2'd2, 1'b0, 64'h8000_0020, 64'h0, 64'h0000_0000_7654_3210);
      n_cmp++; if (rr !== 64'h7654_3210 || lat !== 3 || nreq !== 1)
         begin n_err++; $display("FAIL rst_next got d%h lat%0d n%0d want 76543210 3 1", rr, lat, nreq); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset;
      rst = 1'b0;
      @(negedge clk);
      test_load_word;
      test_loads;
      test_stores;
      test_misalign;
      test_backpressure;
      test_reset_in_wait;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
